// File: rtl/minirisc_pkg.sv
// Shared definitions for the minirisc fetch path: opcode values and FSM state codes.
// Used by minirisc_fetch_queue (optional loop playback via MINIRISC_FETCH_LOOP_EN) and the core.
package minirisc_pkg;

    localparam logic [7:0] OP_IDLE  = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_STORE = 8'h04;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // True for the opcodes the core actually executes (IDLE is a no-op filler).
    function automatic logic is_exec_opcode(input logic [7:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/minirisc_prog_ram.sv
// Program store for the fetch queue: DEPTH x OPW, one synchronous write port,
// one asynchronous read port. Contents are never reset.
module minirisc_prog_ram #(
    parameter int DEPTH = 8,
    parameter int OPW   = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [OPW-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [OPW-1:0]           rdata
);

    logic [OPW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/minirisc_fetch_queue.sv
// Loads a short opcode program, then streams it to the core over a valid/ready handshake.
// Define MINIRISC_FETCH_LOOP_EN to replay the program endlessly instead of stopping in DONE.
module minirisc_fetch_queue
    import minirisc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OPW   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   wr_en,
    input  logic [OPW-1:0]         wr_data,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   op_ready,
    output logic                   op_valid,
    output logic [OPW-1:0]         op_data,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fsm_state_t     state;
    logic [AW-1:0]  rd_ptr;
    logic [OPW-1:0] ram_rdata;
    logic           full;
    logic           wr_accept;
    logic           last_entry;

    assign full       = (count == CW'(DEPTH));
    assign wr_accept  = ena && !clear && (state == ST_IDLE) && wr_en && !full;
    assign last_entry = ({1'b0, rd_ptr} == (count - CW'(1)));

    minirisc_prog_ram #(
        .DEPTH (DEPTH),
        .OPW   (OPW)
    ) u_prog_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (count[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // op_valid/op_data derive only from registered state, so ena=0 freezes them with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                state    <= ST_IDLE;
                count    <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wr_en) begin
                            if (!full) begin
                                count <= count + CW'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        // A same-cycle write makes an empty store startable.
                        if (start && ((count != '0) || wr_en)) begin
                            state  <= ST_RUN;
                            rd_ptr <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (op_ready) begin
                            if (last_entry) begin
`ifdef MINIRISC_FETCH_LOOP_EN
                                rd_ptr <= '0;
`else
                                state  <= ST_DONE;
`endif
                            end else begin
                                rd_ptr <= rd_ptr + AW'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            state  <= ST_RUN;
                            rd_ptr <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign op_valid = (state == ST_RUN);
    assign op_data  = op_valid ? ram_rdata : OPW'(OP_IDLE);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_minirisc_fetch_queue.sv
// Self-checking bench for minirisc_fetch_queue: directed scenarios plus random traffic
// compared cycle by cycle against a queue-level reference model.
module tb_minirisc_fetch_queue;

    localparam int DEPTH = 8;
    localparam int OPW   = 8;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       rst_n, ena, wr_en, start, clear, op_ready;
    logic [7:0] wr_data;
    logic       op_valid, busy, done, overflow;
    logic [7:0] op_data;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: program list, play position, mode 0=idle 1=playing 2=finished.
    logic [7:0] m_prog [DEPTH];
    int         m_count, m_ptr, m_mode;
    bit         m_ovf;
    byte_q_t    stream, exp_q;

    always #5 clk = ~clk;

    minirisc_fetch_queue #(.DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .start    (start),
        .clear    (clear),
        .op_ready (op_ready),
        .op_valid (op_valid),
        .op_data  (op_data),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep();
        if (!rst_n || (ena && clear)) begin
            m_mode = 0; m_count = 0; m_ptr = 0; m_ovf = 1'b0;
        end else if (ena) begin
            if (m_mode == 0) begin
                if (wr_en) begin
                    if (m_count < DEPTH) begin
                        m_prog[m_count] = wr_data;
                        m_count++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (start && m_count > 0) begin
                    m_mode = 1; m_ptr = 0;
                end
            end else if (m_mode == 1) begin
                if (op_ready) begin
                    m_ptr++;
                    if (m_ptr == m_count) begin
                        m_ptr = 0;
`ifndef MINIRISC_FETCH_LOOP_EN
                        m_mode = 2;
`endif
                    end
                end
            end else if (start) begin
                m_mode = 1; m_ptr = 0;
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("op_valid", op_valid, m_mode == 1);
        checkOutput("op_data", op_data, (m_mode == 1) ? m_prog[m_ptr] : 8'h00);
        checkOutput("busy", busy, m_mode == 1);
        checkOutput("done", done, m_mode == 2);
        checkOutput("count", count, m_count);
        checkOutput("overflow", overflow, m_ovf);
    endtask

    // Drives one cycle of inputs, logs any real transfer, then checks against the model.
    task automatic applyStimulus(input logic e, input logic rs, input logic c, input logic w,
                                 input logic [7:0] d, input logic s, input logic r);
        ena = e; rst_n = rs; clear = c; wr_en = w; wr_data = d; start = s; op_ready = r;
        if (rs && e && !c && r && op_valid) stream.push_back(op_data);
        @(posedge clk);
        modelStep();
        #1;
        compareModel();
    endtask

    task automatic writeOp(input logic [7:0] d);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_len"}, stream.size(), exp_q.size());
        for (int i = 0; i < stream.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s_%0d", tag, i), stream[i], exp_q[i]);
        stream.delete();
    endtask

    initial begin
        // Reset
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_valid", op_valid, 0);
        checkOutput("rst_data", op_data, 8'h00);

        // Straight playback with op_ready held high
        for (int i = 1; i <= 4; i++) writeOp(8'(i));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("t37_first", op_data, 8'h01);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        checkStream("t37_stream");
        checkOutput("t37_done", done, 1);
        checkOutput("t37_valid", op_valid, 0);
        checkOutput("t37_data", op_data, 8'h00);

        // Replay from DONE with op_ready toggling
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, (i % 2) == 0);
        checkStream("t38_stream");
        checkOutput("t38_count", count, 4);

        // Overflow on the ninth write
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) writeOp(8'h10 + 8'(i));
        checkOutput("t39_count", count, 8);
        checkOutput("t39_ovf", overflow, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        checkStream("t39_stream");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t39_clr_count", count, 0);
        checkOutput("t39_clr_ovf", overflow, 0);

        // Clear with the second opcode pending voids that handshake
        writeOp(8'h01);
        writeOp(8'h02);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t40_pending", op_data, 8'h02);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t40_valid", op_valid, 0);
        checkOutput("t40_busy", busy, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("t40_start_ign", op_valid, 0);
        exp_q = '{8'h01};
        checkStream("t40_stream");

        // ena low for three cycles mid-run freezes everything
        writeOp(8'h03);
        writeOp(8'h04);
        writeOp(8'h01);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            checkOutput($sformatf("t42_hold_%0d", i), op_data, 8'h04);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        exp_q = '{8'h03, 8'h04, 8'h01};
        checkStream("t42_stream");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Two-entry program: loops in loop mode, otherwise stops in DONE
        writeOp(8'h02);
        writeOp(8'h03);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef MINIRISC_FETCH_LOOP_EN
        exp_q = '{8'h02, 8'h03, 8'h02, 8'h03, 8'h02, 8'h03};
        checkOutput("t41_done", done, 0);
`else
        exp_q = '{8'h02, 8'h03};
        checkOutput("t41_done", done, 1);
`endif
        checkStream("t41_stream");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] d;
            d = ($urandom % 6 < 5) ? 8'($urandom % 5) : 8'($urandom);
            applyStimulus(($urandom % 8) != 0, ($urandom % 200) != 0, ($urandom % 40) == 0,
                          ($urandom % 3) == 0, d, ($urandom % 8) == 0, ($urandom % 2) == 0);
        end
        stream.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/minirisc_fetch_queue.md
MINIRISC_FETCH_QUEUE -- requirements
Module: minirisc_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of program entries (power of two, 2..16).
REQ-002 Parameter OPW, default 8, opcode width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ena  input  1  design enable; low freezes all registers and outputs.
REQ-006 wr_en  input  1  program-load strobe.
REQ-007 wr_data  input  OPW  opcode to append (01 LOAD, 02 ADD, 03 SUB, 04 STORE, 00 IDLE).
REQ-008 start  input  1  begin playback from entry 0.
REQ-009 clear  input  1  discard program and return to IDLE.
REQ-010 op_ready  input  1  core accepts the current opcode.
REQ-011 op_valid  output  1  op_data holds a program opcode.
REQ-012 op_data  output  OPW  opcode to the core; 00 whenever op_valid=0.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.
REQ-015 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-016 overflow  output  1  sticky; a write was dropped because the store was full.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-018 In IDLE, wr_en with count<DEPTH SHALL write wr_data at index count and increment count the same edge.
REQ-019 In IDLE, wr_en with count==DEPTH SHALL drop the data, leave count unchanged and set overflow.
REQ-020 In RUN and DONE, wr_en SHALL be ignored and SHALL NOT set overflow.
REQ-021 In IDLE, start with count>0, or with wr_en accepted the same cycle, SHALL enter RUN with rd_ptr=0; the run SHALL include any same-cycle write.
REQ-022 In IDLE, start with count==0 and no accepted write SHALL be ignored.
REQ-023 op_valid SHALL rise in the cycle after the edge that samples start (1-cycle latency), with op_data=entry[0].
REQ-024 In RUN, op_valid SHALL stay 1 and op_data SHALL stay stable until a cycle with op_valid&op_ready (transfer).
REQ-025 On a transfer with rd_ptr<count-1, rd_ptr SHALL increment and the next entry SHALL appear the following cycle, with no bubble.
REQ-026 On a transfer of entry count-1, the block SHALL go to DONE and drop op_valid the following cycle.
REQ-027 In DONE, start SHALL replay from entry 0 (enter RUN) with the program and count retained.
REQ-028 clear SHALL take priority over every other input in any state: next state IDLE, count=0, rd_ptr=0, overflow=0, op_valid=0; a same-cycle handshake is void.
REQ-029 ena=0 SHALL hold all registers, including the op_valid/op_data pair, so that no handshake is lost.

Reset
REQ-030 With rst_n=0 at a clock edge, the block SHALL set state=IDLE, count=0, rd_ptr=0, overflow=0, op_valid=0, op_data=00, busy=0 and done=0.
REQ-031 Program store contents SHALL NOT require reset.
REQ-032 Reset mid-RUN SHALL abandon the run with no further op_valid.

Configuration
REQ-033 With macro MINIRISC_FETCH_LOOP_EN defined, a transfer of entry count-1 SHALL wrap rd_ptr to 0 and remain in RUN; in that mode done never asserts and only clear or reset exits RUN.
REQ-034 Without MINIRISC_FETCH_LOOP_EN, the behaviour SHALL be as in REQ-026.

Structure
REQ-035 Package minirisc_pkg SHALL hold the opcode constants (OP_IDLE=00, OP_LOAD=01, OP_ADD=02, OP_SUB=03, OP_STORE=04) and the FSM state enum shared with the core.
REQ-036 Program storage SHALL be a sub-module minirisc_prog_ram (DEPTH x OPW, 1 write port, 1 asynchronous read port).

Verification
REQ-037 Write 01,02,03,04, then start, with op_ready=1 -> op_data 01,02,03,04 on consecutive cycles, then done=1, op_valid=0, op_data=00.
REQ-038 Same program with op_ready toggling 1,0 -> each opcode held stable while op_ready=0; order 01..04 preserved; no duplicates or drops.
REQ-039 Nine writes with DEPTH=8 -> count=8, overflow=1, ninth value absent from playback; clear -> count=0, overflow=0.
REQ-040 Assert clear during RUN with the second opcode pending -> next cycle op_valid=0, state IDLE; start is then ignored with count=0.
REQ-041 Program 02,03 with MINIRISC_FETCH_LOOP_EN defined -> stream 02,03,02,03,...; done stays 0 until clear.
REQ-042 Drop ena for 3 cycles mid-RUN with op_ready=1 -> outputs frozen and no transfer counted; the stream resumes at the same entry.
